// File: rtl/mul_ctrl_fsm.sv
// mul_ctrl_fsm: control-path sequencer for the repeated-addition multiplier.
// Takes operand A then B over the shared din bus (op_valid/op_ready). It then
// steps P += A, B -= 1 until the datapath reports B == 0, and pulses done.
// Optional feature: define MUL_CTRL_ABORT_EN to add the abort/aborted ports.
module mul_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             eqz,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             ld_p,
  output logic             dec_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
`ifdef MUL_CTRL_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ADD,
    S_DONE
  } state_t;

  state_t state, state_nxt;
  logic   kill;

`ifdef MUL_CTRL_ABORT_EN
  // Abort only means something once an operation is under way.
  assign kill = abort && (state != S_IDLE);

  // One-cycle acknowledge, the cycle after the abort was taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted <= 1'b0;
    else        aborted <= kill;
  end
`else
  assign kill = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and strobe decode; load strobes are qualified by op_valid.
  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    clr_p     = 1'b0;
    ld_p      = 1'b0;
    dec_b     = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        op_ready = 1'b1;
        if (op_valid) begin
          ld_a      = 1'b1;
          state_nxt = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        op_ready = 1'b1;
        if (op_valid) begin
          ld_b      = 1'b1;
          clr_p     = 1'b1;
          state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        if (!eqz) begin
          ld_p  = 1'b1;
          dec_b = 1'b1;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over op_valid and eqz: no strobes, straight back to IDLE.
    if (kill) begin
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      clr_p     = 1'b0;
      ld_p      = 1'b0;
      dec_b     = 1'b0;
      done      = 1'b0;
      state_nxt = S_IDLE;
    end
  end

  // Addition counter: cleared when B is loaded, bumped with every decrement.
  // It holds after done so software can read the last operation's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     iter_cnt <= '0;
    else if (ld_b)  iter_cnt <= '0;
    else if (dec_b) iter_cnt <= iter_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_mul_ctrl_fsm.sv
// Self-checking bench for mul_ctrl_fsm. A small datapath (A, B, P registers)
// follows the DUT strobes; expected results come from plain arithmetic
// (product = A*B, additions = B, done at cycle stalls + B + 4).
module tb_mul_ctrl_fsm;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         op_ready, eqz, ld_a, ld_b, clr_p, ld_p, dec_b, busy, done;
  logic [W-1:0] iter_cnt;
`ifdef MUL_CTRL_ABORT_EN
  logic         abort = 1'b0;
  logic         aborted;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] dp_a = '0;
  logic [W-1:0] dp_b = '0;
  logic [31:0]  dp_p = '0;

  always #5 clk = ~clk;

  mul_ctrl_fsm #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid),
    .op_ready(op_ready), .eqz(eqz), .ld_a(ld_a), .ld_b(ld_b),
    .clr_p(clr_p), .ld_p(ld_p), .dec_b(dec_b), .busy(busy), .done(done),
    .iter_cnt(iter_cnt)
`ifdef MUL_CTRL_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  // Datapath stand-in driven by the sequencer's strobes.
  assign eqz = (dp_b == '0);
  always @(posedge clk) begin
    if (ld_a) dp_a <= din;
    if (ld_b) dp_b <= din;
    else if (dec_b) dp_b <= dp_b - 16'd1;
    if (clr_p) dp_p <= '0;
    else if (ld_p) dp_p <= dp_p + {16'd0, dp_a};
  end

  typedef struct {
    int ld_a_cyc, ld_b_cyc, clrp_cyc, done_cyc;
    int n_lda, n_ldb, nldp, first_ldp, last_ldp;
    int busy_cyc, rdy_cyc, bad;
    int iter_done, iter_after, busy_a1, done_a1, busy_a2, rdy_a2;
    logic [31:0] prod;
  } obs_t;

  // Operand bus schedule: op_valid low for sa cycles in LOAD_A, sb in LOAD_B.
  task automatic drive(input int cyc, input int sa, input int sb,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = (cyc == sa + 1) || (cyc >= sa + sb + 2);
    din      = (cyc <= sa + 1) ? a : b;
  endtask

  // Runs one operation and records what the DUT did, cycle by cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int sa, input int sb, input bit hold,
                        output obs_t o);
    int cyc, lim;
    o = '{default: 0};
    o.ld_a_cyc = -1; o.ld_b_cyc = -1; o.clrp_cyc = -1; o.done_cyc = -1;
    o.first_ldp = -1; o.last_ldp = -1;
    lim = sa + sb + int'(b) + 40;
    @(negedge clk); start = 1'b1; op_valid = 1'b0;
    @(posedge clk);
    cyc = 0;
    do begin
      #1; cyc++; start = hold; drive(cyc, sa, sb, a, b);
      @(negedge clk);
      if (o.done_cyc < 0) begin
        if (ld_a) begin o.n_lda++; if (o.ld_a_cyc < 0) o.ld_a_cyc = cyc; end
        if (ld_b) begin o.n_ldb++; if (o.ld_b_cyc < 0) o.ld_b_cyc = cyc; end
        if (clr_p && o.clrp_cyc < 0) o.clrp_cyc = cyc;
        if (ld_p) begin o.nldp++; o.last_ldp = cyc; if (o.first_ldp < 0) o.first_ldp = cyc; end
        if (busy) o.busy_cyc++;
        if (op_ready) o.rdy_cyc++;
        if ((ld_a && ld_b) || (ld_p !== dec_b) || (ld_p && (ld_a || ld_b || clr_p))) o.bad++;
        if (done) begin o.done_cyc = cyc; o.prod = dp_p; o.iter_done = int'(iter_cnt); end
      end else if (cyc == o.done_cyc + 1) begin
        o.busy_a1 = int'(busy); o.done_a1 = int'(done); o.iter_after = int'(iter_cnt);
      end else begin
        o.busy_a2 = int'(busy); o.rdy_a2 = int'(op_ready);
      end
      @(posedge clk);
    end while (cyc < lim && !(o.done_cyc >= 0 && cyc >= o.done_cyc + 2));
    #1; start = 1'b0; op_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if ({op_ready, ld_a, ld_b, clr_p, ld_p, dec_b, busy, done} !== 8'h00) begin n_err++; $display("FAIL reset_outs got %b want 00000000", {op_ready, ld_a, ld_b, clr_p, ld_p, dec_b, busy, done}); end
    n_chk++; if (iter_cnt !== 16'd0) begin n_err++; $display("FAIL reset_iter got %0d want 0", iter_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if ({op_ready, ld_a, ld_b, clr_p, ld_p, dec_b, busy, done} !== 8'h00) begin n_err++; $display("FAIL idle_outs got %b want 00000000", {op_ready, ld_a, ld_b, clr_p, ld_p, dec_b, busy, done}); end
    n_chk++; if (iter_cnt !== 16'd0) begin n_err++; $display("FAIL idle_iter got %0d want 0", iter_cnt); end
  endtask

  task automatic test_basic();
    obs_t o;
    run_op(16'd7, 16'd3, 0, 0, 1'b0, o);
    n_chk++; if (o.ld_a_cyc != 1) begin n_err++; $display("FAIL basic_lda_cyc got %0d want 1", o.ld_a_cyc); end
    n_chk++; if (o.ld_b_cyc != 2) begin n_err++; $display("FAIL basic_ldb_cyc got %0d want 2", o.ld_b_cyc); end
    n_chk++; if (o.clrp_cyc != 2) begin n_err++; $display("FAIL basic_clrp_cyc got %0d want 2", o.clrp_cyc); end
    n_chk++; if (o.nldp != 3 || o.first_ldp != 3 || o.last_ldp != 5) begin n_err++; $display("FAIL basic_ldp got n=%0d %0d..%0d want n=3 3..5", o.nldp, o.first_ldp, o.last_ldp); end
    n_chk++; if (o.done_cyc != 7) begin n_err++; $display("FAIL basic_done_cyc got %0d want 7", o.done_cyc); end
    n_chk++; if (o.prod !== 32'd21) begin n_err++; $display("FAIL basic_prod got %0d want 21", o.prod); end
    n_chk++; if (o.iter_done != 3 || o.iter_after != 3) begin n_err++; $display("FAIL basic_iter got %0d/%0d want 3/3", o.iter_done, o.iter_after); end
    n_chk++; if (o.busy_cyc != 7 || o.busy_a1 != 0 || o.done_a1 != 0) begin n_err++; $display("FAIL basic_busy got %0d a1=%0d done_a1=%0d want 7 0 0", o.busy_cyc, o.busy_a1, o.done_a1); end
    n_chk++; if (o.rdy_cyc != 2) begin n_err++; $display("FAIL basic_ready got %0d want 2", o.rdy_cyc); end
    n_chk++; if (o.bad != 0) begin n_err++; $display("FAIL basic_strobe_combo got %0d want 0", o.bad); end
  endtask

  task automatic test_b_zero();
    obs_t o;
    run_op(16'hFFFF, 16'd0, 0, 0, 1'b0, o);
    n_chk++; if (o.nldp != 0) begin n_err++; $display("FAIL bzero_ldp got %0d want 0", o.nldp); end
    n_chk++; if (o.done_cyc != 4) begin n_err++; $display("FAIL bzero_done_cyc got %0d want 4", o.done_cyc); end
    n_chk++; if (o.prod !== 32'd0) begin n_err++; $display("FAIL bzero_prod got %0d want 0", o.prod); end
    n_chk++; if (o.iter_done != 0) begin n_err++; $display("FAIL bzero_iter got %0d want 0", o.iter_done); end
  endtask

  task automatic test_stall();
    obs_t o;
    run_op(16'd5, 16'd2, 2, 3, 1'b0, o);
    n_chk++; if (o.ld_a_cyc != 3 || o.n_lda != 1) begin n_err++; $display("FAIL stall_lda got cyc %0d n %0d want 3 1", o.ld_a_cyc, o.n_lda); end
    n_chk++; if (o.ld_b_cyc != 7 || o.n_ldb != 1) begin n_err++; $display("FAIL stall_ldb got cyc %0d n %0d want 7 1", o.ld_b_cyc, o.n_ldb); end
    n_chk++; if (o.done_cyc != 11) begin n_err++; $display("FAIL stall_done_cyc got %0d want 11", o.done_cyc); end
    n_chk++; if (o.prod !== 32'd10) begin n_err++; $display("FAIL stall_prod got %0d want 10", o.prod); end
    n_chk++; if (o.rdy_cyc != 7) begin n_err++; $display("FAIL stall_ready got %0d want 7", o.rdy_cyc); end
  endtask

  task automatic test_start_ignored();
    obs_t o;
    bit seen;
    run_op(16'd6, 16'd2, 0, 0, 1'b1, o);
    n_chk++; if (o.done_cyc != 6 || o.n_lda != 1) begin n_err++; $display("FAIL busystart_done got cyc %0d lda %0d want 6 1", o.done_cyc, o.n_lda); end
    n_chk++; if (o.prod !== 32'd12) begin n_err++; $display("FAIL busystart_prod got %0d want 12", o.prod); end
    n_chk++; if (o.busy_a1 != 0 || o.busy_a2 != 1 || o.rdy_a2 != 1) begin n_err++; $display("FAIL busystart_restart got busy %0d,%0d rdy %0d want 0,1 1", o.busy_a1, o.busy_a2, o.rdy_a2); end
    // Let the restarted operation finish so the next test starts from IDLE.
    op_valid = 1'b1; din = 16'd1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); if (done) seen = 1'b1;
    end
    n_chk++; if (!seen) begin n_err++; $display("FAIL busystart_second_done got none want pulse"); end
    @(posedge clk); #1; op_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit   dseen;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      #1; start = 1'b0; drive(cyc, 0, 0, 16'd3, 16'd10);
      @(negedge clk);
      if (cyc == 6) begin
        n_chk++; if (iter_cnt !== 16'd3) begin n_err++; $display("FAIL rstmid_pre_iter got %0d want 3", iter_cnt); end
      end
      if (cyc < 6) @(posedge clk);
    end
    #2; rst_n = 1'b0; #1;
    n_chk++; if (busy !== 1'b0 || iter_cnt !== 16'd0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_async got busy %b iter %0d done %b want 0 0 0", busy, iter_cnt, done); end
    dseen = 1'b0;
    repeat (2) begin @(negedge clk); if (done) dseen = 1'b1; end
    rst_n = 1'b1; op_valid = 1'b0;
    repeat (2) begin @(negedge clk); if (done || busy) dseen = 1'b1; end
    n_chk++; if (dseen) begin n_err++; $display("FAIL rstmid_nodone got activity want idle"); end
    run_op(16'd2, 16'd4, 0, 0, 1'b0, o);
    n_chk++; if (o.prod !== 32'd8 || o.done_cyc != 8 || o.iter_done != 4) begin n_err++; $display("FAIL rstmid_rerun got prod %0d done %0d iter %0d want 8 8 4", o.prod, o.done_cyc, o.iter_done); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [W-1:0] a, b;
    int sa, sb, exp_done;
    logic [31:0] exp_prod;
    for (int k = 0; k < 12; k++) begin
      a  = W'($urandom_range(0, 65535));
      b  = W'($urandom_range(0, 12));
      sa = int'($urandom_range(0, 3));
      sb = int'($urandom_range(0, 3));
      exp_done = sa + sb + int'(b) + 4;
      exp_prod = 32'(a) * 32'(b);
      run_op(a, b, sa, sb, 1'b0, o);
      n_chk++; if (o.done_cyc != exp_done) begin n_err++; $display("FAIL rand%0d_done_cyc got %0d want %0d", k, o.done_cyc, exp_done); end
      n_chk++; if (o.prod !== exp_prod) begin n_err++; $display("FAIL rand%0d_prod got %0d want %0d", k, o.prod, exp_prod); end
      n_chk++; if (o.iter_after != int'(b) || o.nldp != int'(b)) begin n_err++; $display("FAIL rand%0d_iter got %0d ldp %0d want %0d", k, o.iter_after, o.nldp, b); end
      n_chk++; if (o.ld_a_cyc != sa + 1 || o.ld_b_cyc != sa + sb + 2 || o.bad != 0) begin n_err++; $display("FAIL rand%0d_loads got %0d %0d bad %0d want %0d %0d 0", k, o.ld_a_cyc, o.ld_b_cyc, o.bad, sa + 1, sa + sb + 2); end
    end
  endtask

`ifdef MUL_CTRL_ABORT_EN
  task automatic test_abort();
    bit dseen;
    dseen = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      #1; start = 1'b0; drive(cyc, 0, 0, 16'd4, 16'd6); abort = (cyc == 4);
      @(negedge clk);
      if (done) dseen = 1'b1;
      if (cyc == 4) begin
        n_chk++; if ({ld_a, ld_b, clr_p, ld_p, dec_b, done, aborted} !== 7'b0) begin n_err++; $display("FAIL abort_strobes got %b want 0000000", {ld_a, ld_b, clr_p, ld_p, dec_b, done, aborted}); end
      end
      if (cyc == 5) begin
        n_chk++; if (aborted !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL abort_pulse got aborted %b busy %b want 1 0", aborted, busy); end
      end
      if (cyc == 6) begin
        n_chk++; if (aborted !== 1'b0) begin n_err++; $display("FAIL abort_one_cycle got %b want 0", aborted); end
      end
      @(posedge clk);
    end
    #1; abort = 1'b0; op_valid = 1'b0;
    n_chk++; if (iter_cnt !== 16'd1) begin n_err++; $display("FAIL abort_iter got %0d want 1", iter_cnt); end
    n_chk++; if (dseen || busy !== 1'b0) begin n_err++; $display("FAIL abort_idle got done_seen %b busy %b want 0 0", dseen, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_b_zero();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_random();
`ifdef MUL_CTRL_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Time limit so a stuck DUT cannot hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "time limit");
  end
endmodule
